rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
Parametrised successor to the fixed full-screen filler. It fills an arbitrary clipped rectangle on the VGA adapter framebuffer, one pixel per clock, using a selectable colour pattern (solid, column stripes, row stripes or checker). It sits between the task control logic and the VGA adapter pixel-write port, and uses the lab's start/done handshake.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width
SCREEN_W, 160, visible columns (x valid 0..SCREEN_W-1)
SCREEN_H, 120, visible rows (y valid 0..SCREEN_H-1)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  synchronous, active-high reset
start  in  1  request; level-held by requester until done seen
x0  in  X_W  left column, inclusive
y0  in  Y_W  top row, inclusive
x1  in  X_W  right column, inclusive
y1  in  Y_W  bottom row, inclusive
colour  in  COLOUR_W  base colour
mode  in  2  0=SOLID 1=COLSTRIPE 2=ROWSTRIPE 3=CHECKER
busy  out  1  high while in FILL
done  out  1  fill complete, held until start low
err  out  1  valid with done; request was empty or off-screen
vga_x  out  X_W  pixel column
vga_y  out  Y_W  pixel row
vga_colour  out  COLOUR_W  pixel colour
vga_plot  out  1  write strobe, one pixel per high cycle

Behaviour:
- One clock (clk). Reset is synchronous, active-high. Reset forces state IDLE and drives every output to 0. It takes effect on any cycle, including mid-fill. On the cycle after reset, vga_plot=0; no further plots occur until a new start.
- States: IDLE, FILL, DONE. All outputs are registered.
- IDLE and start=1: latch x0, y0, x1, y1, colour and mode. Later input changes are ignored until return to IDLE.
- Clip: cx1=min(x1,SCREEN_W-1), cy1=min(y1,SCREEN_H-1).
- Invalid request (x0>x1, y0>y1, x0>=SCREEN_W or y0>=SCREEN_H): go to DONE with err=1. Zero plots.
- Valid request: go to FILL with counters at (x0,y0).
- FILL: each cycle asserts vga_plot=1 with the current (vga_x,vga_y). Scan is x-outer, y-inner: y increments to cy1, then y returns to y0 and x increments. First plot is visible the cycle after acceptance.
- After plotting (cx1,cy1), go to DONE. done=1 in the cycle after the last plot; vga_plot=0 that cycle. busy=0.
- Total plots = (cx1-x0+1)*(cy1-y0+1), exactly once each, with no gaps between plots.
- DONE: done (and err, if set) held. When start=0, return to IDLE and clear done/err next cycle.
- start held high through DONE does not retrigger a fill.
- Counter compares use the clipped bounds, so no wrap at the X_W/Y_W limit. x=255 is never reached with the defaults.
- Pattern, per plotted pixel:
  - SOLID: colour.
  - COLSTRIPE: vga_x[COLOUR_W-1:0].
  - ROWSTRIPE: vga_y[COLOUR_W-1:0].
  - CHECKER: colour if (x[2]^y[2])==0, else ~colour.
- vga_x, vga_y and vga_colour hold their last values when vga_plot=0.

Decomposition:
- Package rect_fill_pkg: fill_mode_t enum (SOLID, COLSTRIPE, ROWSTRIPE, CHECKER), state_t enum (IDLE, FILL, DONE), default SCREEN_W/SCREEN_H constants.
- Sub-module fill_pattern: combinational; inputs x, y, colour, mode; output pixel colour. It is shared with future circle/Reuleaux fillers.

Test Plan:
- Solid 2x3: (10,20)-(11,22), colour=3, mode=SOLID -> 6 consecutive plots in order (10,20),(10,21),(10,22),(11,20),(11,21),(11,22), all colour 3. done on the 7th cycle after acceptance; err=0.
- Full screen: (0,0)-(159,119), COLSTRIPE -> exactly 19200 plots, each pixel unique. Pixel (5,7) has colour 5; pixel (159,0) has colour 7.
- Clipping: (150,110)-(200,127), SOLID -> 100 plots, max vga_x=159, max vga_y=119, no plot outside the screen.
- Error: x0=20, x1=10 -> zero plots; done=1 and err=1 one cycle after acceptance. Dropping start clears both the next cycle.
- Checker: colour=3'b010 -> pixel (0,0)=3'b010, (4,0)=3'b101, (4,4)=3'b010.
- Reset after 50 plots: vga_plot=0 and busy=0 the next cycle. With start held through DONE there is no second fill. A new start after reset runs the full count correctly.

Source files
------------

// File: rtl/rect_fill_engine_pkg.sv
// Shared types and screen defaults for the rectangle fill engine
// and related framebuffer fillers.
package rect_fill_pkg;

   typedef enum logic [1:0] {
      SOLID     = 2'd0,
      COLSTRIPE = 2'd1,
      ROWSTRIPE = 2'd2,
      CHECKER   = 2'd3
   } fill_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_fill_engine_fill_pattern.sv
// Per-pixel colour generator; purely combinational so any scan-based
// filler can reuse it.
module fill_pattern
   import rect_fill_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
) (
   input  logic [X_W-1:0]      x,
   input  logic [Y_W-1:0]      y,
   input  logic [COLOUR_W-1:0] colour,
   input  fill_mode_t          mode,
   output logic [COLOUR_W-1:0] pix
);

   always_comb begin
      pix = colour;
      case (mode)
         SOLID:     pix = colour;
         COLSTRIPE: pix = x[COLOUR_W-1:0];
         ROWSTRIPE: pix = y[COLOUR_W-1:0];
         CHECKER:   pix = (x[2] ^ y[2]) ? ~colour : colour;
         default:   pix = colour;
      endcase
   end

endmodule

// File: rtl/rect_fill_engine.sv
// Clipped rectangle filler for the VGA adapter: one registered pixel
// write per clock, column-major scan, start/done handshake.
module rect_fill_engine
   import rect_fill_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [X_W-1:0]      x0,
   input  logic [Y_W-1:0]      y0,
   input  logic [X_W-1:0]      x1,
   input  logic [Y_W-1:0]      y1,
   input  logic [COLOUR_W-1:0] colour,
   input  logic [1:0]          mode,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot
);

   localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

   state_t              state, state_d;
   logic [Y_W-1:0]      y0_l;
   logic [X_W-1:0]      cx1_l;
   logic [Y_W-1:0]      cy1_l;
   logic [COLOUR_W-1:0] colour_l;
   fill_mode_t          mode_l;

   logic                load;
   logic                req_bad;
   logic [X_W-1:0]      cx1_c;
   logic [Y_W-1:0]      cy1_c;
   logic [X_W-1:0]      nx;
   logic [Y_W-1:0]      ny;
   logic                last;

   logic [X_W-1:0]      pat_x;
   logic [Y_W-1:0]      pat_y;
   logic [COLOUR_W-1:0] pat_colour;
   fill_mode_t          pat_mode;
   logic [COLOUR_W-1:0] pix;

   logic                plot_d, busy_d, done_d, err_d;
   logic [X_W-1:0]      x_d;
   logic [Y_W-1:0]      y_d;
   logic [COLOUR_W-1:0] col_d;

   always_comb begin
      cx1_c   = (x1 > X_MAX) ? X_MAX : x1;
      cy1_c   = (y1 > Y_MAX) ? Y_MAX : y1;
      req_bad = (x0 > x1) || (y0 > y1) || (x0 > X_MAX) || (y0 > Y_MAX);
   end

   // vga_x/vga_y double as the scan counters; bounds are the clipped ones
   always_comb begin
      last = (vga_x == cx1_l) && (vga_y == cy1_l);
      if (vga_y == cy1_l) begin
         nx = vga_x + 1'b1;
         ny = y0_l;
      end else begin
         nx = vga_x;
         ny = vga_y + 1'b1;
      end
   end

   // On acceptance the first pixel's colour comes straight from the ports
   always_comb begin
      if (state == IDLE) begin
         pat_x      = x0;
         pat_y      = y0;
         pat_colour = colour;
         pat_mode   = fill_mode_t'(mode);
      end else begin
         pat_x      = nx;
         pat_y      = ny;
         pat_colour = colour_l;
         pat_mode   = mode_l;
      end
   end

   fill_pattern #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .COLOUR_W (COLOUR_W)
   ) u_pattern (
      .x      (pat_x),
      .y      (pat_y),
      .colour (pat_colour),
      .mode   (pat_mode),
      .pix    (pix)
   );

   always_comb begin
      state_d = state;
      load    = 1'b0;
      plot_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      x_d     = vga_x;
      y_d     = vga_y;
      col_d   = vga_colour;
      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               if (req_bad) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = FILL;
                  plot_d  = 1'b1;
                  busy_d  = 1'b1;
                  x_d     = x0;
                  y_d     = y0;
                  col_d   = pix;
               end
            end
         end
         FILL: begin
            if (last) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               plot_d = 1'b1;
               busy_d = 1'b1;
               x_d    = nx;
               y_d    = ny;
               col_d  = pix;
            end
         end
         DONE: begin
            if (start) begin
               done_d = 1'b1;
               err_d  = err;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         y0_l       <= '0;
         cx1_l      <= '0;
         cy1_l      <= '0;
         colour_l   <= '0;
         mode_l     <= SOLID;
         vga_plot   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         state      <= state_d;
         vga_plot   <= plot_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         vga_x      <= x_d;
         vga_y      <= y_d;
         vga_colour <= col_d;
         if (load) begin
            y0_l     <= y0;
            cx1_l    <= cx1_c;
            cy1_l    <= cy1_c;
            colour_l <= colour;
            mode_l   <= fill_mode_t'(mode);
         end
      end
   end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine: scan order, counts,
// patterns, clipping, error requests, handshake and mid-fill reset.
module tb_rect_fill_engine;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [X_W-1:0] x0, x1;
   logic [Y_W-1:0] y0, y1;
   logic [C_W-1:0] colour;
   logic [1:0]     mode;
   logic           busy, done, err, vga_plot;
   logic [X_W-1:0] vga_x;
   logic [Y_W-1:0] vga_y;
   logic [C_W-1:0] vga_colour;

   always #5 clk = ~clk;

   rect_fill_engine #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .COLOUR_W (C_W),
      .SCREEN_W (160),
      .SCREEN_H (120)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x0         (x0),
      .y0         (y0),
      .x1         (x1),
      .y1         (y1),
      .colour     (colour),
      .mode       (mode),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int       plots, dups, offs, gaps, done_cyc, max_x, max_y;
   logic     err_at_done, busy_at_done, plot_at_done, busy_first;
   bit       seen [160][120];
   logic [2:0] cmap [160][120];
   int       fx [8];
   int       fy [8];
   int       fc [8];

   task automatic clear_stats();
      plots = 0; dups = 0; offs = 0; gaps = 0; done_cyc = 0;
      max_x = 0; max_y = 0; busy_first = 1'b0;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) begin
            seen[i][j] = 1'b0;
            cmap[i][j] = '0;
         end
   endtask

   task automatic record();
      if (int'(vga_x) < 160 && int'(vga_y) < 120) begin
         if (seen[vga_x][vga_y]) dups++;
         seen[vga_x][vga_y] = 1'b1;
         cmap[vga_x][vga_y] = vga_colour;
      end else begin
         offs++;
      end
      if (plots < 8) begin
         fx[plots] = vga_x;
         fy[plots] = vga_y;
         fc[plots] = vga_colour;
      end
      if (plots == 0) busy_first = busy;
      plots++;
      if (int'(vga_x) > max_x) max_x = vga_x;
      if (int'(vga_y) > max_y) max_y = vga_y;
   endtask

   // Called at a negedge; returns just after the acceptance edge with
   // the request inputs scrambled, which the engine must ignore.
   task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int acol, input int amode);
      x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
      colour = C_W'(acol); mode = 2'(amode); start = 1'b1;
      @(posedge clk);
      #1;
      x0 = '0; y0 = '0; x1 = '1; y1 = '1; colour = ~colour; mode = ~mode;
   endtask

   task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int acol, input int amode, input int budget);
      clear_stats();
      launch(ax0, ay0, ax1, ay1, acol, amode);
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (vga_plot) record();
         else if (!done) gaps++;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      if (done_cyc == 0) check("timeout", done, 1);
      err_at_done  = err;
      busy_at_done = busy;
      plot_at_done = vga_plot;
   endtask

   task automatic release_start(input string tag);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_done_clr"}, done, 0);
      check({tag, "_err_clr"}, err, 0);
   endtask

   initial begin
      int ex [6];
      int ey [6];
      int n;
      ex = '{10, 10, 10, 11, 11, 11};
      ey = '{20, 21, 22, 20, 21, 22};

      rst = 1'b1; start = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0; mode = '0;
      repeat (3) @(negedge clk);
      check("rst_plot", vga_plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_x", vga_x, 0);
      check("rst_y", vga_y, 0);
      check("rst_colour", vga_colour, 0);
      rst = 1'b0;
      @(negedge clk);

      // Solid 2x3, then start held through DONE
      run_fill(10, 20, 11, 22, 3, 0, 20);
      check("solid_plots", plots, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("solid_x%0d", i), fx[i], ex[i]);
         check($sformatf("solid_y%0d", i), fy[i], ey[i]);
         check($sformatf("solid_c%0d", i), fc[i], 3);
      end
      check("solid_done_cyc", done_cyc, 7);
      check("solid_err", err_at_done, 0);
      check("solid_gaps", gaps, 0);
      check("solid_busy_fill", busy_first, 1);
      check("solid_busy_done", busy_at_done, 0);
      check("solid_plot_done", plot_at_done, 0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (vga_plot) n++;
      end
      check("hold_no_refill", n, 0);
      check("hold_done", done, 1);
      release_start("solid");

      // Full screen column stripes
      run_fill(0, 0, 159, 119, 0, 1, 19300);
      check("full_plots", plots, 19200);
      check("full_dups", dups, 0);
      check("full_offs", offs, 0);
      check("full_gaps", gaps, 0);
      check("full_done_cyc", done_cyc, 19201);
      check("full_px5_7", cmap[5][7], 5);
      check("full_px159_0", cmap[159][0], 7);
      check("full_px12_3", cmap[12][3], 4);
      release_start("full");

      // Clipping at the bottom-right corner
      run_fill(150, 110, 200, 127, 6, 0, 200);
      check("clip_plots", plots, 100);
      check("clip_max_x", max_x, 159);
      check("clip_max_y", max_y, 119);
      check("clip_offs", offs, 0);
      check("clip_dups", dups, 0);
      check("clip_colour", cmap[150][110], 6);
      release_start("clip");

      // Empty and off-screen requests
      run_fill(20, 5, 10, 9, 1, 0, 10);
      check("errx_plots", plots, 0);
      check("errx_done_cyc", done_cyc, 1);
      check("errx_err", err_at_done, 1);
      release_start("errx");
      run_fill(0, 120, 5, 126, 1, 0, 10);
      check("erry_plots", plots, 0);
      check("erry_err", err_at_done, 1);
      release_start("erry");

      // Checker
      run_fill(0, 0, 4, 4, 2, 3, 40);
      check("chk_plots", plots, 25);
      check("chk_0_0", cmap[0][0], 3'b010);
      check("chk_4_0", cmap[4][0], 3'b101);
      check("chk_4_4", cmap[4][4], 3'b010);
      check("chk_0_4", cmap[0][4], 3'b101);
      release_start("chk");

      // Reset after 50 plots of a full-screen fill
      clear_stats();
      launch(0, 0, 159, 119, 0, 0);
      for (int c = 0; c < 200 && plots < 50; c++) begin
         @(negedge clk);
         if (vga_plot) record();
      end
      check("mid_plots", plots, 50);
      rst = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("mid_rst_plot", vga_plot, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (vga_plot) n++;
      end
      check("mid_no_plots", n, 0);

      // Fresh fill after reset, row stripes
      run_fill(3, 4, 6, 9, 0, 2, 60);
      check("row_plots", plots, 24);
      check("row_done_cyc", done_cyc, 25);
      check("row_dups", dups, 0);
      check("row_px3_9", cmap[3][9], 1);
      check("row_px6_4", cmap[6][4], 4);
      release_start("row");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
